// File: rtl/brownout_pkg.sv
// ============================================================================
// brownout_pkg : shared types, counter width and default timing constants
// Revision     : 1.0
// ============================================================================
`default_nettype none

package brownout_pkg;

    localparam int CNT_W              = 11;
    localparam int STARTUP_CYC_DEF    = 64;
    localparam int DEB_CYC_DEF        = 4;
    localparam int HOLD_CYC_DEF       = 1024;
    localparam int HOLD_SHORT_CYC_DEF = 16;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_STARTUP  = 3'd1,
        ST_MONITOR  = 3'd2,
        ST_DEBOUNCE = 3'd3,
        ST_HOLD     = 3'd4
    } bo_state_t;

    function automatic logic [7:0] onehot8(input logic [2:0] sel);
        onehot8 = 8'd1 << sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/brownout_if.sv
// ============================================================================
// brownout_if : analog-facing signal bundle of the brownout digital block
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface brownout_if;

    logic       ena;
    logic       force_short_oneshot;
    logic [2:0] otrip;
    logic [2:0] vtrip;
    logic       dcomp;
    logic       vunder;
    logic [7:0] otrip_decoded;
    logic [7:0] vtrip_decoded;
    logic       out_unbuf;
    logic       vunder_sync;
    logic       timed_out;

    modport master (
        output ena, force_short_oneshot, otrip, vtrip, dcomp, vunder,
        input  otrip_decoded, vtrip_decoded, out_unbuf, vunder_sync, timed_out
    );

    modport slave (
        input  ena, force_short_oneshot, otrip, vtrip, dcomp, vunder,
        output otrip_decoded, vtrip_decoded, out_unbuf, vunder_sync, timed_out
    );

endinterface

`default_nettype wire

// File: rtl/brownout_sync.sv
// ============================================================================
// brownout_sync : two-flop synchronizer, asynchronous active-low clear
// Revision      : 1.0
// ============================================================================
`default_nettype none

module brownout_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/brownout_dig.sv
// ============================================================================
// brownout_dig : brownout detector control - sync, debounce, hold, tap decode
// Revision     : 1.0
// ============================================================================
`default_nettype none

module brownout_dig
    import brownout_pkg::*;
#(
    parameter int STARTUP_CYC    = STARTUP_CYC_DEF,
    parameter int DEB_CYC        = DEB_CYC_DEF,
    parameter int HOLD_CYC       = HOLD_CYC_DEF,
    parameter int HOLD_SHORT_CYC = HOLD_SHORT_CYC_DEF
) (
    input  wire logic osc_ck,
    input  wire logic resetb,
    brownout_if.slave bo
);

    localparam logic [CNT_W-1:0] c_startup_load = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_deb_load     = CNT_W'(DEB_CYC - 2);
    localparam logic [CNT_W-1:0] c_hold_load    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_short_load   = CNT_W'(HOLD_SHORT_CYC - 1);

    logic             w_rst_n;
    logic             w_dcomp_s;
    logic             w_vunder_s;
    bo_state_t        r_state;
    bo_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;
    logic [CNT_W-1:0] w_hold_reload;
    logic             w_cnt_zero;
    logic             w_out_unbuf;
    logic             w_timed_out;
    logic [7:0]       r_otrip_dec;
    logic [7:0]       r_vtrip_dec;

    // Reset asserts through the synchronizer's async clear, releases two edges later
    brownout_sync u_rst_sync (
        .clk   (osc_ck),
        .rst_n (resetb),
        .i_d   (1'b1),
        .o_q   (w_rst_n)
    );

    brownout_sync u_dcomp_sync (
        .clk   (osc_ck),
        .rst_n (w_rst_n),
        .i_d   (bo.dcomp),
        .o_q   (w_dcomp_s)
    );

    brownout_sync u_vunder_sync (
        .clk   (osc_ck),
        .rst_n (w_rst_n),
        .i_d   (bo.vunder),
        .o_q   (w_vunder_s)
    );

    assign w_cnt_zero    = (r_cnt == '0);
    assign w_cnt_dec     = w_cnt_zero ? r_cnt : (r_cnt - CNT_W'(1));
    assign w_hold_reload = bo.force_short_oneshot ? c_short_load : c_hold_load;

    always_ff @(posedge osc_ck or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!bo.ena) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_STARTUP;
                    w_cnt_nxt   = c_startup_load;
                end
                ST_STARTUP: begin
                    if (!w_cnt_zero) begin
                        w_cnt_nxt = w_cnt_dec;
                    end else if (w_dcomp_s) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = w_hold_reload;
                    end else begin
                        w_state_nxt = ST_MONITOR;
                    end
                end
                ST_MONITOR: begin
                    if (w_dcomp_s) begin
                        w_state_nxt = ST_DEBOUNCE;
                        w_cnt_nxt   = c_deb_load;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_dcomp_s) begin
                        w_state_nxt = ST_MONITOR;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_zero) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = w_hold_reload;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                    end
                end
                ST_HOLD: begin
                    // force_short_oneshot only matters at a reload; a running countdown keeps its length
                    if (w_dcomp_s) begin
                        w_cnt_nxt = w_hold_reload;
                    end else if (w_cnt_zero) begin
                        w_state_nxt = ST_MONITOR;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_out_unbuf = 1'b1;
        w_timed_out = 1'b0;
        case (r_state)
            ST_MONITOR, ST_DEBOUNCE: w_out_unbuf = 1'b0;
            ST_HOLD:                 w_timed_out = bo.ena && !w_dcomp_s && w_cnt_zero;
            default:                 w_out_unbuf = 1'b1;
        endcase
    end

    always_ff @(posedge osc_ck or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_otrip_dec <= '0;
            r_vtrip_dec <= '0;
        end else if (bo.ena) begin
            r_otrip_dec <= onehot8(bo.otrip);
            r_vtrip_dec <= onehot8(bo.vtrip);
        end else begin
            r_otrip_dec <= '0;
            r_vtrip_dec <= '0;
        end
    end

    assign bo.out_unbuf     = w_out_unbuf;
    assign bo.timed_out     = w_timed_out;
    assign bo.vunder_sync   = w_vunder_s;
    assign bo.otrip_decoded = r_otrip_dec;
    assign bo.vtrip_decoded = r_vtrip_dec;

endmodule

`default_nettype wire

// File: tb/tb_brownout_dig.sv
// ============================================================================
// tb_brownout_dig : directed self-checking bench for brownout_dig
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_brownout_dig;

    logic osc_ck;
    logic resetb;
    int   n_cmp;
    int   n_err;

    brownout_if bo ();

    brownout_dig u_dut (
        .osc_ck (osc_ck),
        .resetb (resetb),
        .bo     (bo.slave)
    );

    initial osc_ck = 1'b0;
    always #5 osc_ck = ~osc_ck;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge osc_ck);
            #1;
        end
    endtask

    // Ticks until out_unbuf reaches lvl; returns tick count or -1 on budget expiry
    task automatic wait_out(input logic lvl, input int budget, output int cnt);
        cnt = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bo.out_unbuf === lvl) begin
                cnt = i;
                break;
            end
        end
    endtask

    int n;
    int pulse_at;
    int n_pulse;
    int fall_at;
    logic seen_low;

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetb = 1'b0;
        bo.ena = 1'b0;
        bo.force_short_oneshot = 1'b0;
        bo.otrip = 3'd0;
        bo.vtrip = 3'd0;
        bo.dcomp = 1'b0;
        bo.vunder = 1'b1;

        tick(3);
        check_val("rst_out_unbuf", 32'(bo.out_unbuf), 32'd1);
        check_val("rst_timed_out", 32'(bo.timed_out), 32'd0);
        check_val("rst_vunder_sync", 32'(bo.vunder_sync), 32'd0);
        check_val("rst_otrip_dec", 32'(bo.otrip_decoded), 32'h00);

        resetb = 1'b1;
        tick(6);
        check_val("vunder_sync_hi", 32'(bo.vunder_sync), 32'd1);
        bo.vunder = 1'b0;
        tick(3);
        check_val("vunder_sync_lo", 32'(bo.vunder_sync), 32'd0);

        // Startup: 1 OFF cycle + 64 STARTUP cycles before MONITOR
        bo.ena = 1'b1;
        bo.otrip = 3'd3;
        bo.vtrip = 3'd5;
        tick();
        check_val("otrip_dec", 32'(bo.otrip_decoded), 32'h08);
        check_val("vtrip_dec", 32'(bo.vtrip_decoded), 32'h20);
        check_val("startup_out_hi", 32'(bo.out_unbuf), 32'd1);
        wait_out(1'b0, 200, n);
        check_val("startup_len", 32'(n), 32'd64);

        // Three high samples do not declare brownout
        bo.dcomp = 1'b1;
        tick(3);
        bo.dcomp = 1'b0;
        seen_low = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bo.out_unbuf !== 1'b0) seen_low = 1'b0;
        end
        check_val("deb3_no_trip", 32'(seen_low), 32'd1);

        // Four high samples trip; hold then expires 1026 ticks after dcomp falls
        bo.dcomp = 1'b1;
        tick(4);
        bo.dcomp = 1'b0;
        tick();
        check_val("deb4_pre_trip", 32'(bo.out_unbuf), 32'd0);
        tick();
        check_val("deb4_trip", 32'(bo.out_unbuf), 32'd1);
        pulse_at = -1; n_pulse = 0; fall_at = -1;
        for (int i = 3; i <= 1100; i++) begin
            tick();
            if (bo.timed_out === 1'b1) begin
                n_pulse++;
                pulse_at = i;
            end
            if (fall_at < 0 && bo.out_unbuf === 1'b0) fall_at = i;
        end
        check_val("hold_pulse_at", 32'(pulse_at), 32'd1025);
        check_val("hold_pulse_cnt", 32'(n_pulse), 32'd1);
        check_val("hold_fall_at", 32'(fall_at), 32'd1026);

        // Short hold, dcomp re-pulse restarts from 15; mid-count mode change ignored
        bo.force_short_oneshot = 1'b1;
        bo.dcomp = 1'b1;
        tick(10);
        check_val("short_in_hold", 32'(bo.out_unbuf), 32'd1);
        bo.dcomp = 1'b0;
        pulse_at = -1; n_pulse = 0; fall_at = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 10) bo.dcomp = 1'b1;
            if (i == 11) bo.dcomp = 1'b0;
            if (i == 20) bo.force_short_oneshot = 1'b0;
            if (bo.timed_out === 1'b1) begin
                n_pulse++;
                pulse_at = i;
            end
            if (fall_at < 0 && bo.out_unbuf === 1'b0) fall_at = i;
        end
        check_val("short_pulse_at", 32'(pulse_at), 32'd28);
        check_val("short_pulse_cnt", 32'(n_pulse), 32'd1);
        check_val("short_fall_at", 32'(fall_at), 32'd29);

        // ena drop mid-HOLD
        bo.dcomp = 1'b1;
        tick(10);
        bo.dcomp = 1'b0;
        tick(5);
        bo.ena = 1'b0;
        tick();
        check_val("off_otrip_dec", 32'(bo.otrip_decoded), 32'h00);
        check_val("off_vtrip_dec", 32'(bo.vtrip_decoded), 32'h00);
        check_val("off_out_unbuf", 32'(bo.out_unbuf), 32'd1);
        n_pulse = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (bo.timed_out === 1'b1) n_pulse++;
        end
        check_val("off_no_timeout", 32'(n_pulse), 32'd0);
        bo.ena = 1'b1;
        wait_out(1'b0, 200, n);
        check_val("restart_len", 32'(n), 32'd65);

        // Async reset mid-DEBOUNCE
        bo.vunder = 1'b1;
        tick(4);
        bo.dcomp = 1'b1;
        tick(4);
        check_val("deb_pre_rst", 32'(bo.out_unbuf), 32'd0);
        #2;
        resetb = 1'b0;
        #1;
        check_val("arst_out_unbuf", 32'(bo.out_unbuf), 32'd1);
        check_val("arst_vunder_sync", 32'(bo.vunder_sync), 32'd0);
        check_val("arst_otrip_dec", 32'(bo.otrip_decoded), 32'h00);
        check_val("arst_vtrip_dec", 32'(bo.vtrip_decoded), 32'h00);
        check_val("arst_timed_out", 32'(bo.timed_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/brownout_dig.md
BROWNOUT_DIG -- requirements
Module: brownout_dig

Interface
REQ-001 SHALL provide parameter STARTUP_CYC, default 64, analog settle time after ena rises (osc_ck cycles).
REQ-002 SHALL provide parameter DEB_CYC, default 4, consecutive high samples of synced dcomp needed to declare brownout.
REQ-003 SHALL provide parameter HOLD_CYC, default 1024, brownout hold time after dcomp falls.
REQ-004 SHALL provide parameter HOLD_SHORT_CYC, default 16, hold time when force_short_oneshot=1.
REQ-005 SHALL have ports osc_ck  in  1  sole clock, rising edge.
REQ-006 SHALL have ports resetb  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports ena  in  1  block enable.
REQ-008 SHALL have ports force_short_oneshot  in  1  selects HOLD_SHORT_CYC.
REQ-009 SHALL have ports otrip  in  3  brownout trip select; vtrip  in  3  undervoltage trip select.
REQ-010 SHALL have ports dcomp  in  1  async brownout comparator output (1 = supply below trip); vunder  in  1  async undervoltage flag.
REQ-011 SHALL have ports otrip_decoded  out  8  and vtrip_decoded  out  8  one-hot tap selects to the resistor-string mux.
REQ-012 SHALL have ports out_unbuf  out  1  filtered brownout indication; vunder_sync  out  1  synchronized vunder; timed_out  out  1  one-cycle pulse at hold expiry.

Function
REQ-013 dcomp and vunder SHALL each pass through a 2-flop synchronizer; vunder_sync = second flop of vunder path.
REQ-014 otrip_decoded/vtrip_decoded SHALL be registered: bit[otrip]/bit[vtrip] set, others 0, when ena=1; all-zero when ena=0; update 1 cycle after input change.
REQ-015 FSM states SHALL be OFF, STARTUP, MONITOR, DEBOUNCE, HOLD, with one shared 11-bit down-counter.
REQ-016 OFF: out_unbuf=1; ena=1 -> STARTUP, counter=STARTUP_CYC-1.
REQ-017 STARTUP: out_unbuf=1; counter decrements; at 0 -> MONITOR if synced dcomp=0, else HOLD.
REQ-018 MONITOR: out_unbuf=0; synced dcomp=1 -> DEBOUNCE, counter=DEB_CYC-2.
REQ-019 DEBOUNCE: out_unbuf=0; synced dcomp=0 -> MONITOR; counter reaching 0 with dcomp=1 -> HOLD (out_unbuf=1 from next cycle), i.e. brownout declared after DEB_CYC consecutive high samples.
REQ-020 HOLD: out_unbuf=1; while synced dcomp=1 counter reloads hold value (HOLD_SHORT_CYC-1 if force_short_oneshot else HOLD_CYC-1); while 0 counter decrements; at 0 -> MONITOR with timed_out=1 for that cycle.
REQ-021 force_short_oneshot SHALL be sampled only at each reload; changes mid-countdown take effect at next reload.
REQ-022 ena=0 in any state SHALL force OFF next cycle, out_unbuf=1, counter=0, decoded outputs zero; ena re-assertion restarts STARTUP.
REQ-023 Counter SHALL never wrap; decrement at 0 does not occur.
REQ-024 timed_out SHALL be 0 in all cycles other than REQ-020 expiry.

Reset
REQ-025 resetb=0 SHALL asynchronously force state OFF, counter 0, synchronizer flops 0, out_unbuf=1, vunder_sync=0, timed_out=0, otrip_decoded=vtrip_decoded=0.
REQ-026 Reset release SHALL be synchronous to osc_ck via 2-flop reset synchronizer (async assert, sync deassert).
REQ-027 Reset asserted mid-HOLD SHALL abandon the countdown; no timed_out pulse.

Structure
REQ-028 State enum, counter width constant (11) and default cycle constants SHALL reside in package brownout_pkg.
REQ-029 The 2-flop synchronizer SHALL be one sub-module, brownout_sync, instantiated for dcomp, vunder and reset release.

Verification
REQ-030 Reset then ena=1, dcomp=0: out_unbuf=1 for 64+sync cycles, then 0; otrip=3 -> otrip_decoded=8'h08.
REQ-031 In MONITOR, dcomp high 3 cycles then low: out_unbuf stays 0; dcomp high 4 cycles: out_unbuf=1.
REQ-032 Brownout then dcomp low: out_unbuf falls exactly 1024 cycles after synced dcomp low, timed_out pulses once.
REQ-033 force_short_oneshot=1: hold 16 cycles; dcomp re-pulses at hold cycle 10 -> countdown restarts from 15.
REQ-034 ena=0 mid-HOLD: OFF next cycle, decoded outputs 0, out_unbuf=1, no timed_out.
REQ-035 resetb asserted mid-DEBOUNCE: all outputs at reset values immediately, without a clock edge.
